// File: rtl/piso_serializer_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the bit-serial link transmitter.
//   piso_state_t : serializer FSM encoding (IDLE, SHIFT).
//   cnt_w()      : bit-counter width for a given word length. It never
//                  returns less than 1, so the counter always has at least
//                  one bit.
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a
// valid/ready handshake and sends it one bit per enabled cycle. Each bit
// carries strobes that mark the first and last bit of the word.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   en         shift enable; 0 stalls the shifter without losing data
//   din        parallel word
//   din_valid  din holds a word to send
//   din_ready  word is accepted this cycle (combinational)
//   sout       serial data bit (registered)
//   sout_en    sout carries a new bit this cycle (registered)
//   sof        sout is the first bit of a word (registered)
//   eof        sout is the last bit of a word (registered)
//   busy       a word is loaded and not yet fully shifted out
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_en_q, sout_en_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic last_s;
  logic accept_s;
  logic out_bit_s;

  assign last_s = (cnt_q == CNT_LAST);

  // The last enabled bit also opens the input, so the next word is loaded on
  // the same edge that emits eof and back-to-back words leave no idle bit.
  assign din_ready = !rst && ((state_q == IDLE) ||
                              ((state_q == SHIFT) && en && last_s));
  assign accept_s  = din_valid && din_ready;

  assign out_bit_s = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  // Next-state, shifter and output-strobe logic.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    sout_d    = sout_q;
    sout_en_d = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sreg_d  = din;
          cnt_d   = CNT_ZERO;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (en) begin
          sout_d    = out_bit_s;
          sout_en_d = 1'b1;
          sof_d     = (cnt_q == CNT_ZERO);
          eof_d     = last_s;
          if (MSB_FIRST) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          end else begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (last_s) begin
            if (accept_s) begin
              sreg_d  = din;
              cnt_d   = CNT_ZERO;
              state_d = SHIFT;
            end else begin
              cnt_d   = CNT_ZERO;
              state_d = IDLE;
            end
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= {WIDTH{1'b0}};
      cnt_q     <= CNT_ZERO;
      sout_q    <= 1'b0;
      sout_en_q <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      sout_q    <= sout_d;
      sout_en_q <= sout_en_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
    end
  end

  assign sout    = sout_q;
  assign sout_en = sout_en_q;
  assign sof     = sof_q;
  assign eof     = eof_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer. Accepted words push their expected bit
// stream into a queue, and a negedge monitor pops one entry per sout_en
// pulse. A second instance with MSB_FIRST=0 covers LSB-first ordering.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic sof;
    logic eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, sout, sout_en, sof, eof, busy;
  logic [7:0] din1;
  logic       v1;
  logic       ready1, sout1, sout_en1, sof1, eof1, busy1;

  int   checks = 0;
  int   errors = 0;
  int   pops0 = 0;
  int   run = 0;
  int   max_run = 0;
  int   base;
  bit   mon_on = 1'b0;
  bit   hold_chk = 1'b0;
  logic last_sout = 1'b0;
  logic en_at_edge = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_en(sout_en), .sof(sof),
    .eof(eof), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .din(din1), .din_valid(v1),
    .din_ready(ready1), .sout(sout1), .sout_en(sout_en1), .sof(sof1),
    .eof(eof1), .busy(busy1)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w, input bit lsb);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b   = lsb ? w[i] : w[7-i];
      e.sof = (i == 0);
      e.eof = (i == 7);
      if (lsb) q1.push_back(e);
      else     q0.push_back(e);
    end
  endtask

  // Present a word and wait (bounded) for the accepting edge; returns just after it.
  task automatic offer(input logic [7:0] w);
    bit got;
    got       = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      if (din_ready) begin
        @(posedge clk);
        push_word(w, 1'b0);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("drain", q0.size() + q1.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pops(input int n);
    for (int k = 0; k < 60; k++) begin
      #1;
      if (pops0 - base >= n) break;
      @(negedge clk);
    end
    chk("pop_wait", {31'd0, (pops0 - base >= n)}, 32'd1);
  endtask

  always @(posedge clk) en_at_edge <= en;

  // Scoreboard monitor for the MSB-first instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (sout_en) begin
        if (q0.size() == 0) begin
          chk("unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          chk("sout", {31'd0, sout}, {31'd0, e.b});
          chk("sof", {31'd0, sof}, {31'd0, e.sof});
          chk("eof", {31'd0, eof}, {31'd0, e.eof});
          pops0++;
        end
        chk("bit_after_en", {31'd0, en_at_edge}, 32'd1);
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
        chk("strobe_idle", {30'd0, sof, eof}, 32'd0);
        if (hold_chk) chk("sout_hold", {31'd0, sout}, {31'd0, last_sout});
      end
      last_sout = sout;
    end
  end

  // Scoreboard monitor for the LSB-first instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (sout_en1) begin
        if (q1.size() == 0) begin
          chk("lsb_unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("lsb_sout", {31'd0, sout1}, {31'd0, e.b});
          chk("lsb_sof", {31'd0, sof1}, {31'd0, e.sof});
          chk("lsb_eof", {31'd0, eof1}, {31'd0, e.eof});
        end
      end else begin
        chk("lsb_strobe_idle", {30'd0, sof1, eof1}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; din = 8'hEE; din_valid = 1'b1; din1 = 8'h00; v1 = 1'b0;

    // Reset state, with din_valid high to show din_ready stays low.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {27'd0, sout, sout_en, sof, eof, busy}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_busy_lsb", {31'd0, busy1}, 32'd0);
    din_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, din_ready}, 32'd1);
    mon_on = 1'b1;

    // Single word 8'hA5: latency, busy and din_ready window.
    offer(8'hA5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) din_valid = 1'b0;
      #1;
      chk("a5_ready", {31'd0, din_ready}, {31'd0, (i == 7)});
      chk("a5_busy", {31'd0, busy}, 32'd1);
      if (i == 0) chk("a5_no_bit_yet", {31'd0, sout_en}, 32'd0);
      if (i == 1) chk("a5_first_bit", {30'd0, sout_en, sof}, 32'd3);
    end
    drain();
    chk("a5_idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back words 8'hA5, 8'h3C: one unbroken run of 16 bits.
    max_run = 0;
    offer(8'hA5);
    @(negedge clk);
    offer(8'h3C);
    @(negedge clk);
    din_valid = 1'b0;
    drain();
    chk("b2b_run", max_run, 32'd16);

    // Alternating enable during 8'hF0: sout holds through stalls.
    hold_chk = 1'b1;
    base = pops0;
    offer(8'hF0);
    repeat (24) begin
      @(negedge clk);
      din_valid = 1'b0;
      en = ~en;
    end
    en = 1'b1;
    drain();
    hold_chk = 1'b0;
    chk("toggle_pulses", pops0 - base, 32'd8);

    // LSB-first instance with 8'h01.
    din1 = 8'h01;
    v1 = 1'b1;
    #1;
    chk("lsb_ready", {31'd0, ready1}, 32'd1);
    @(posedge clk);
    push_word(8'h01, 1'b1);
    @(negedge clk);
    v1 = 1'b0;
    drain();

    // Reset after three bits of 8'hFF, then 8'h80.
    base = pops0;
    offer(8'hFF);
    @(negedge clk);
    din_valid = 1'b0;
    wait_pops(3);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    #1;
    chk("midrst_outputs", {27'd0, sout, sout_en, sof, eof, busy}, 32'd0);
    chk("midrst_ready", {31'd0, din_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_release", {31'd0, din_ready}, 32'd1);
    offer(8'h80);
    @(negedge clk);
    din_valid = 1'b0;
    drain();

    // 8'h55 offered during 8'h0F is held off until the last-bit cycle.
    base = pops0;
    offer(8'h0F);
    @(negedge clk);
    din_valid = 1'b0;
    wait_pops(3);
    din = 8'h55;
    din_valid = 1'b1;
    #1;
    chk("busy_not_ready", {31'd0, din_ready}, 32'd0);
    offer(8'h55);
    chk("handoff_at_last", pops0 - base, 32'd7);
    @(negedge clk);
    din_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
